// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter, the decoder and the benches.
// The functions work on a 32-bit container. Narrower codes are
// zero-extended on the way in and truncated on the way out. Zero upper
// bits do not disturb the prefix-XOR decode.
package gray_pkg;

   localparam int MAX_WIDTH = 32;

   // Reflected-binary encode: each Gray bit is the XOR of adjacent binary bits.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Decode: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to reflected-binary Gray encoder.
// This is the exact inverse of gray_to_binary.
module binary_to_gray
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter with binary and Gray outputs.
// Both codes are registered from the same next-state value, so they never
// disagree. The wrap output pulses for one cycle after a counting step that
// rolled over.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
   localparam logic [WIDTH-1:0] TERMINAL   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] bin_r;
   logic [WIDTH-1:0] gray_r;
   logic             wrap_r;
   logic [WIDTH-1:0] next_bin_s;
   logic [WIDTH-1:0] next_gray_s;
   logic             next_wrap_s;

   // Next-state selection with priority clear > load > count > hold.
   // Wrap is taken from the current value against its terminal, not from a carry.
   always_comb begin
      next_bin_s  = bin_r;
      next_wrap_s = 1'b0;
      if (clear) begin
         next_bin_s  = RESET_BIN;
         next_wrap_s = 1'b0;
      end else if (load) begin
         next_bin_s  = load_val;
         next_wrap_s = 1'b0;
      end else if (en) begin
         if (up) begin
            next_bin_s  = bin_r + ONE;
            next_wrap_s = (bin_r == TERMINAL);
         end else begin
            next_bin_s  = bin_r - ONE;
            next_wrap_s = (bin_r == ZERO);
         end
      end else begin
         next_bin_s  = bin_r;
         next_wrap_s = 1'b0;
      end
   end

   // Gray is encoded from the next binary value, never from the old one.
   binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
      .bin  (next_bin_s),
      .gray (next_gray_s)
   );

   // Output registers. An asynchronous reset also drops any pending wrap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_r  <= RESET_BIN;
         gray_r <= RESET_GRAY;
         wrap_r <= 1'b0;
      end else begin
         bin_r  <= next_bin_s;
         gray_r <= next_gray_s;
         wrap_r <= next_wrap_s;
      end
   end

   assign bin  = bin_r;
   assign gray = gray_r;
   assign wrap = wrap_r;

endmodule
